// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RV32I pipeline types: result select, ALU ops, control bundle
package riscv_pkg;

   typedef enum logic [1:0] {
      RES_ALU = 2'b00,
      RES_MEM = 2'b01,
      RES_PC4 = 2'b10
   } result_src_e;

   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_SUB = 4'b0001;
   localparam logic [3:0] ALU_AND = 4'b0010;
   localparam logic [3:0] ALU_OR  = 4'b0011;
   localparam logic [3:0] ALU_XOR = 4'b0100;
   localparam logic [3:0] ALU_SLT = 4'b0101;
   localparam logic [3:0] ALU_SLL = 4'b0110;
   localparam logic [3:0] ALU_SRL = 4'b0111;
   localparam logic [3:0] ALU_SRA = 4'b1000;

   typedef struct packed {
      logic        RegWrite;
      logic        MemWrite;
      logic        Jump;
      logic        Branch;
      logic        ALUSrc;
      result_src_e ResultSrc;
      logic [3:0]  ALUControl;
   } ctrl_t;

   // A bubble is an all-zero control word: no side effects downstream.
   localparam ctrl_t CTRL_BUBBLE = '{
      RegWrite:   1'b0,
      MemWrite:   1'b0,
      Jump:       1'b0,
      Branch:     1'b0,
      ALUSrc:     1'b0,
      ResultSrc:  RES_ALU,
      ALUControl: ALU_ADD
   };

endpackage

// File: rtl/wb_bypass.sv
// rtl/wb_bypass.sv - single read port WB->ID bypass: replaces stale register-file data with ResultW
module wb_bypass #(
   parameter int XLEN   = 32,
   parameter int REG_AW = 5
) (
   input  logic              wb_we_i,
   input  logic [REG_AW-1:0] wb_rd_i,
   input  logic [XLEN-1:0]   wb_result_i,
   input  logic [REG_AW-1:0] rs_addr_i,
   input  logic [XLEN-1:0]   rf_data_i,
   output logic [XLEN-1:0]   rs_data_o
);

   logic hit;

   // x0 is hardwired zero, so a write to it must never be forwarded.
   assign hit       = wb_we_i && (wb_rd_i != '0) && (wb_rd_i == rs_addr_i);
   assign rs_data_o = hit ? wb_result_i : rf_data_i;

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with WB bypass, load-use stall and flush bubbles
module id_ex_stage
   import riscv_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int REG_AW = 5,
   parameter int CNT_W  = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [REG_AW-1:0] A1D,
   input  logic [REG_AW-1:0] A2D,
   input  logic [REG_AW-1:0] RdD,
   input  logic [XLEN-1:0]   RD1D,
   input  logic [XLEN-1:0]   RD2D,
   input  logic [XLEN-1:0]   ImmExtD,
   input  logic [XLEN-1:0]   PCD,
   input  logic [XLEN-1:0]   PCPlus4D,
   input  logic              RegWriteD,
   input  logic              MemWriteD,
   input  logic              JumpD,
   input  logic              BranchD,
   input  logic              ALUSrcD,
   input  logic [1:0]        ResultSrcD,
   input  logic [3:0]        ALUControlD,
   input  logic              RegWriteW,
   input  logic [REG_AW-1:0] RdW,
   input  logic [XLEN-1:0]   ResultW,
   input  logic              FlushE,
   output logic [XLEN-1:0]   RD1E,
   output logic [XLEN-1:0]   RD2E,
   output logic [XLEN-1:0]   ImmExtE,
   output logic [XLEN-1:0]   PCE,
   output logic [XLEN-1:0]   PCPlus4E,
   output logic [REG_AW-1:0] A1E,
   output logic [REG_AW-1:0] A2E,
   output logic [REG_AW-1:0] RdE,
   output logic              RegWriteE,
   output logic              MemWriteE,
   output logic              JumpE,
   output logic              BranchE,
   output logic              ALUSrcE,
   output logic [1:0]        ResultSrcE,
   output logic [3:0]        ALUControlE,
   output logic              ValidE,
   output logic              StallF,
   output logic              StallD,
   output logic [CNT_W-1:0]  BubbleCnt
);

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [XLEN-1:0]   fwd1, fwd2;
   logic              lw_stall, bubble;

   ctrl_t             ctrl_q, ctrl_d;
   logic [XLEN-1:0]   rd1_q, rd1_d, rd2_q, rd2_d, imm_q, imm_d, pc_q, pc_d, pc4_q, pc4_d;
   logic [REG_AW-1:0] a1_q, a1_d, a2_q, a2_d, rd_q, rd_d;
   logic              valid_q, valid_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   wb_bypass #(.XLEN(XLEN), .REG_AW(REG_AW)) u_bypass_rs1 (
      .wb_we_i     (RegWriteW),
      .wb_rd_i     (RdW),
      .wb_result_i (ResultW),
      .rs_addr_i   (A1D),
      .rf_data_i   (RD1D),
      .rs_data_o   (fwd1)
   );

   wb_bypass #(.XLEN(XLEN), .REG_AW(REG_AW)) u_bypass_rs2 (
      .wb_we_i     (RegWriteW),
      .wb_rd_i     (RdW),
      .wb_result_i (ResultW),
      .rs_addr_i   (A2D),
      .rf_data_i   (RD2D),
      .rs_data_o   (fwd2)
   );

   // Gating on valid_q keeps a bubble from re-triggering the stall, so each load-use costs one cycle.
   assign lw_stall = valid_q && (ctrl_q.ResultSrc == RES_MEM) && (rd_q != '0) &&
                     ((rd_q == A1D) || (rd_q == A2D));
   assign bubble   = FlushE || lw_stall;
   assign StallF   = lw_stall;
   assign StallD   = lw_stall;

   always_comb begin
      ctrl_d  = CTRL_BUBBLE;
      rd1_d   = '0;
      rd2_d   = '0;
      imm_d   = '0;
      pc_d    = '0;
      pc4_d   = '0;
      a1_d    = '0;
      a2_d    = '0;
      rd_d    = '0;
      valid_d = 1'b0;
      cnt_d   = cnt_q;
      if (bubble) begin
         if (cnt_q != '1) begin
            cnt_d = cnt_q + CNT_ONE;
         end
      end else begin
         ctrl_d  = '{
            RegWrite:   RegWriteD,
            MemWrite:   MemWriteD,
            Jump:       JumpD,
            Branch:     BranchD,
            ALUSrc:     ALUSrcD,
            ResultSrc:  result_src_e'(ResultSrcD),
            ALUControl: ALUControlD
         };
         rd1_d   = fwd1;
         rd2_d   = fwd2;
         imm_d   = ImmExtD;
         pc_d    = PCD;
         pc4_d   = PCPlus4D;
         a1_d    = A1D;
         a2_d    = A2D;
         rd_d    = RdD;
         valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ctrl_q  <= CTRL_BUBBLE;
         rd1_q   <= '0;
         rd2_q   <= '0;
         imm_q   <= '0;
         pc_q    <= '0;
         pc4_q   <= '0;
         a1_q    <= '0;
         a2_q    <= '0;
         rd_q    <= '0;
         valid_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         ctrl_q  <= ctrl_d;
         rd1_q   <= rd1_d;
         rd2_q   <= rd2_d;
         imm_q   <= imm_d;
         pc_q    <= pc_d;
         pc4_q   <= pc4_d;
         a1_q    <= a1_d;
         a2_q    <= a2_d;
         rd_q    <= rd_d;
         valid_q <= valid_d;
         cnt_q   <= cnt_d;
      end
   end

   assign RD1E        = rd1_q;
   assign RD2E        = rd2_q;
   assign ImmExtE     = imm_q;
   assign PCE         = pc_q;
   assign PCPlus4E    = pc4_q;
   assign A1E         = a1_q;
   assign A2E         = a2_q;
   assign RdE         = rd_q;
   assign RegWriteE   = ctrl_q.RegWrite;
   assign MemWriteE   = ctrl_q.MemWrite;
   assign JumpE       = ctrl_q.Jump;
   assign BranchE     = ctrl_q.Branch;
   assign ALUSrcE     = ctrl_q.ALUSrc;
   assign ResultSrcE  = ctrl_q.ResultSrc;
   assign ALUControlE = ctrl_q.ALUControl;
   assign ValidE      = valid_q;
   assign BubbleCnt   = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - directed and randomized checks of id_ex_stage against a behavioural model
module tb_id_ex_stage;

   localparam int XLEN    = 32;
   localparam int REG_AW  = 5;
   localparam int CNT_W   = 4;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst;
   logic [REG_AW-1:0] A1D, A2D, RdD, RdW;
   logic [XLEN-1:0]   RD1D, RD2D, ImmExtD, PCD, PCPlus4D, ResultW;
   logic              RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD, RegWriteW, FlushE;
   logic [1:0]        ResultSrcD;
   logic [3:0]        ALUControlD;

   logic [XLEN-1:0]   RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
   logic [REG_AW-1:0] A1E, A2E, RdE;
   logic              RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ValidE, StallF, StallD;
   logic [1:0]        ResultSrcE;
   logic [3:0]        ALUControlE;
   logic [CNT_W-1:0]  BubbleCnt;

   id_ex_stage #(.XLEN(XLEN), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .A1D(A1D), .A2D(A2D), .RdD(RdD), .RD1D(RD1D), .RD2D(RD2D), .ImmExtD(ImmExtD),
      .PCD(PCD), .PCPlus4D(PCPlus4D), .RegWriteD(RegWriteD), .MemWriteD(MemWriteD),
      .JumpD(JumpD), .BranchD(BranchD), .ALUSrcD(ALUSrcD), .ResultSrcD(ResultSrcD),
      .ALUControlD(ALUControlD), .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW),
      .FlushE(FlushE),
      .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .PCE(PCE), .PCPlus4E(PCPlus4E),
      .A1E(A1E), .A2E(A2E), .RdE(RdE), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
      .JumpE(JumpE), .BranchE(BranchE), .ALUSrcE(ALUSrcE), .ResultSrcE(ResultSrcE),
      .ALUControlE(ALUControlE), .ValidE(ValidE), .StallF(StallF), .StallD(StallD),
      .BubbleCnt(BubbleCnt)
   );

   typedef struct packed {
      logic [XLEN-1:0]   rd1, rd2, imm, pc, pc4;
      logic [REG_AW-1:0] a1, a2, rd;
      logic              rw, mw, j, b, as;
      logic [1:0]        rs;
      logic [3:0]        alu;
      logic              v;
   } e_t;

   e_t m_e;
   int m_cnt;
   bit m_known;
   int n_tests, n_fail;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic e_t obs_e();
      return {RD1E, RD2E, ImmExtE, PCE, PCPlus4E, A1E, A2E, RdE, RegWriteE, MemWriteE,
              JumpE, BranchE, ALUSrcE, ResultSrcE, ALUControlE, ValidE};
   endfunction

   // A load sitting in E whose destination is read by D must wait one cycle.
   function automatic bit model_stall();
      return m_e.v && (m_e.rs == 2'b01) && (m_e.rd != 0) && ((m_e.rd == A1D) || (m_e.rd == A2D));
   endfunction

   function automatic logic [XLEN-1:0] model_read(input logic [REG_AW-1:0] a, input logic [XLEN-1:0] rf);
      return (RegWriteW && RdW != 0 && RdW == a) ? ResultW : rf;
   endfunction

   task automatic step();
      bit st;
      e_t nx;
      int ncnt;
      #1;
      st = model_stall();
      if (m_known) begin
         chk("stall_d", StallD, st);
         chk("stall_f", StallF, st);
      end
      nx   = '0;
      ncnt = m_cnt;
      if (rst) begin
         ncnt = 0;
      end else if (FlushE || st) begin
         ncnt = (m_cnt == CNT_MAX) ? CNT_MAX : m_cnt + 1;
      end else begin
         nx.rd1 = model_read(A1D, RD1D);
         nx.rd2 = model_read(A2D, RD2D);
         nx.imm = ImmExtD;  nx.pc = PCD;  nx.pc4 = PCPlus4D;
         nx.a1  = A1D;      nx.a2 = A2D;  nx.rd  = RdD;
         nx.rw  = RegWriteD; nx.mw = MemWriteD; nx.j = JumpD; nx.b = BranchD; nx.as = ALUSrcD;
         nx.rs  = ResultSrcD; nx.alu = ALUControlD; nx.v = 1'b1;
      end
      @(posedge clk);
      #1;
      if (rst) m_known = 1'b1;
      m_e   = nx;
      m_cnt = ncnt;
      chk("e_regs", obs_e(), m_e);
      chk("bubble_cnt", BubbleCnt, m_cnt);
   endtask

   task automatic rand_d();
      A1D = REG_AW'($urandom_range(0, 7));  A2D = REG_AW'($urandom_range(0, 7));
      RdD = REG_AW'($urandom_range(0, 7));
      RD1D = $urandom; RD2D = $urandom; ImmExtD = $urandom; PCD = $urandom; PCPlus4D = PCD + 4;
      RegWriteD = 1'($urandom); MemWriteD = 1'($urandom); JumpD = 1'($urandom);
      BranchD = 1'($urandom); ALUSrcD = 1'($urandom);
      ResultSrcD = 2'($urandom_range(0, 2)); ALUControlD = 4'($urandom_range(0, 8));
   endtask

   task automatic rand_w();
      RegWriteW = 1'($urandom);
      RdW       = REG_AW'($urandom_range(0, 7));
      ResultW   = $urandom;
   endtask

   task automatic load_d(input logic [REG_AW-1:0] rd, input logic [1:0] rs);
      rand_d();
      A1D = 1; A2D = 2; RdD = rd; ResultSrcD = rs; RegWriteD = 1'b1;
   endtask

   int exp_cnt;

   initial begin
      n_tests = 0; n_fail = 0; m_e = '0; m_cnt = 0; m_known = 1'b0;
      rst = 1'b1; FlushE = 1'b0; RegWriteW = 1'b0; RdW = 0; ResultW = 0;
      rand_d();

      // 1: reset with random D inputs
      step();
      rand_d(); rand_w();
      step();
      chk("rst_valid", ValidE, 1'b0);
      chk("rst_cnt", BubbleCnt, 0);
      chk("rst_stalld", StallD, 1'b0);
      rst = 1'b0;

      // 2: WB bypass, then RdW=0 must not forward
      rand_d(); RegWriteW = 1'b1; RdW = 5; ResultW = 32'hDEADBEEF; A1D = 5; RD1D = 0;
      step();
      chk("bypass_rd1", RD1E, 32'hDEADBEEF);
      rand_d(); RegWriteW = 1'b1; RdW = 0; ResultW = 32'hDEADBEEF; A1D = 0; RD1D = 0;
      step();
      chk("bypass_x0", RD1E, 32'h0);
      RegWriteW = 1'b0;

      // 3: load-use stall for exactly one cycle
      rst = 1'b1; step(); rst = 1'b0;
      load_d(7, 2'b01);
      step();
      rand_d(); A1D = 3; A2D = 7;
      #1;
      chk("lu_stalld", StallD, 1'b1);
      chk("lu_stallf", StallF, 1'b1);
      step();
      chk("lu_bubble_rw", RegWriteE, 1'b0);
      chk("lu_bubble_valid", ValidE, 1'b0);
      chk("lu_cnt", BubbleCnt, 1);
      step();
      chk("lu_release_valid", ValidE, 1'b1);
      chk("lu_release_a2", A2E, 7);

      // 4: no stall on lw x0 or on a non-load producer
      load_d(0, 2'b01);
      step();
      rand_d(); A1D = 0;
      #1;
      chk("lw_x0_nostall", StallD, 1'b0);
      step();
      load_d(9, 2'b00);
      step();
      rand_d(); A1D = 9;
      #1;
      chk("alu_nostall", StallD, 1'b0);
      step();

      // 5: flush coinciding with load-use gives one bubble; flush alone gives a bubble without stall
      load_d(7, 2'b01);
      step();
      exp_cnt = m_cnt + 1;
      rand_d(); A1D = 7; FlushE = 1'b1;
      step();
      chk("flush_lu_cnt", BubbleCnt, exp_cnt);
      rand_d(); A1D = 1; A2D = 2;
      #1;
      chk("flush_only_stalld", StallD, 1'b0);
      step();
      chk("flush_only_valid", ValidE, 1'b0);
      FlushE = 1'b0;

      // 6: reset during a stall, then counter saturation
      load_d(7, 2'b01);
      step();
      rand_d(); A1D = 7; rst = 1'b1;
      step();
      rst = 1'b0;
      chk("rst_stall_valid", ValidE, 1'b0);
      chk("rst_stall_cnt", BubbleCnt, 0);
      chk("rst_stall_stalld", StallD, 1'b0);
      FlushE = 1'b1;
      for (int i = 0; i < CNT_MAX + 2; i++) step();
      chk("sat_cnt", BubbleCnt, CNT_MAX);
      step();
      chk("sat_hold", BubbleCnt, CNT_MAX);
      FlushE = 1'b0;

      // randomized traffic; D holds its value while the model predicts a stall
      for (int i = 0; i < 400; i++) begin
         rst    = ($urandom_range(0, 49) == 0);
         FlushE = ($urandom_range(0, 7) == 0);
         rand_w();
         if (!model_stall()) rand_d();
         step();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
